// File: rtl/mcse_security_top.sv
// Security engine top: lifecycle tracking, host secure-boot sequencing over GPIO, scan-chain unlock.
// Latency: every output registered; handshake requests drop the cycle after their ack is sampled.
// Backpressure: none; host progress is paced purely by level-sensitive GPIO acks.
module mcse_security_top #(
    parameter int gpio_N          = 32,
    parameter int gpio_AW         = 32,
    parameter int gpio_PW         = 104,
    parameter int scan_key_width  = 32,
    parameter int scan_key_number = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init_config_n,
    input  logic [gpio_N-1:0]         gpio_in,
    output logic [gpio_N-1:0]         gpio_out,
    input  logic                      lc_transition_request_in,
    input  logic [511:0]              lc_transition_id,
    input  logic                      lc_authentication_valid,
    input  logic [511:0]              lc_authentication_id,
    input  logic [scan_key_width-1:0] scan_key,
    input  logic                      scan_enable,
    output logic                      scan_unlock,
    output logic                      scan_out,
    output logic [31:0]               O_haddr,
    output logic [2:0]                O_hburst,
    output logic                      O_hmastlock,
    output logic [3:0]                O_hprot,
    output logic                      O_hnonsec,
    output logic [2:0]                O_hsize,
    output logic [1:0]                O_htrans,
    output logic [31:0]               O_hwdata,
    output logic                      O_hwrite,
    input  logic [31:0]               I_hrdata,
    input  logic                      I_hready,
    input  logic [1:0]                I_hresp,
    input  logic                      I_hreadyout
);

    typedef enum logic [2:0] {
        LC_TEST   = 3'd0,
        LC_OEM    = 3'd1,
        LC_DEPLOY = 3'd2,
        LC_RECALL = 3'd3,
        LC_EOL    = 3'd4
    } lc_t;

    typedef enum logic [3:0] {
        ST_INIT     = 4'd0,
        ST_RST_REQ  = 4'd1,
        ST_RST_WAIT = 4'd2,
        ST_AUTH_CHK = 4'd3,
        ST_BUS_WAKE = 4'd4,
        ST_OP_REL   = 4'd5,
        ST_IDLE     = 4'd6
    } state_t;

    localparam logic [255:0] TID_TEST_OEM      = 256'h33a344a35afd82155e5a6ef2d092085d704dc70561dde45d27962d79ea56a24a;
    localparam logic [255:0] TID_OEM_DEPLOY    = 256'h988b6a57b75f5696f01b8207b1c99bc888b4a2421a0ab4b29bd302f5b8a93348;
    localparam logic [255:0] TID_DEPLOY_RECALL = 256'h4893565d146d9fa19dc850e0c409b2a62ec5cb53eea4d4719c93a882f988284e;
    localparam logic [255:0] TID_RECALL_EOL    = 256'hcabc36e4f52fcd1a8b62d82d975e4c8595da7f6df52e2143174c3dc8b3870e03;
    localparam logic [255:0] AID_OEM           = 256'h431909d9da263164ab4d39614e0c50a32774a49b3390a53ffa63e8d74b8e7c0b;
    localparam logic [255:0] AID_DEPLOY        = 256'h8e30701845bea3e44d0aed1ba6d4893a0de91fea6f42571d3714a3c6daa39978;
    localparam logic [255:0] AID_RECALL        = 256'hd995f5ddfb1625e3a33b0ee123b6672f35df88d6652eaec51d26f3a50b030ad8;
    localparam logic [255:0] AID_EOL           = 256'hdf0f326b1bf6611d944491d7a0618af56ac57e391ba38425f9f33cafdd7439a9;

    localparam logic [4:0] KEY_DONE = 5'(scan_key_number);

    function automatic logic [511:0] trans_id_of(input lc_t lc);
        case (lc)
            LC_TEST:   trans_id_of = {2{TID_TEST_OEM}};
            LC_OEM:    trans_id_of = {2{TID_OEM_DEPLOY}};
            LC_DEPLOY: trans_id_of = {2{TID_DEPLOY_RECALL}};
            LC_RECALL: trans_id_of = {2{TID_RECALL_EOL}};
            default:   trans_id_of = '0;
        endcase
    endfunction

    function automatic logic [511:0] auth_id_of(input lc_t lc);
        case (lc)
            LC_OEM:    auth_id_of = {2{AID_OEM}};
            LC_DEPLOY: auth_id_of = {2{AID_DEPLOY}};
            LC_RECALL: auth_id_of = {2{AID_RECALL}};
            LC_EOL:    auth_id_of = {2{AID_EOL}};
            default:   auth_id_of = '0;
        endcase
    endfunction

    function automatic logic [31:0] challenge_word(input logic [3:0] idx);
        case (idx)
            4'd0:    challenge_word = 32'hEF01_2345;
            4'd1:    challenge_word = 32'h6789_ABCD;
            4'd2:    challenge_word = 32'hEF01_2345;
            4'd3:    challenge_word = 32'h7891_ABCD;
            4'd4:    challenge_word = 32'h3D4E_5F60;
            4'd5:    challenge_word = 32'hFF8A_0B2C;
            4'd6:    challenge_word = 32'hFA1B_C49D;
            4'd7:    challenge_word = 32'h87A5_E932;
            default: challenge_word = 32'h0000_0000;
        endcase
    endfunction

    state_t     state;
    lc_t        lc;
    logic       rst_req;
    logic       bus_wake;
    logic       op_rel;
    logic [4:0] key_idx;
    logic [31:0] shreg;

    logic auth_ok;
    logic trans_hit;
    logic commit;

    // EOL never authenticates, so the host stays parked in reset for good.
    assign auth_ok   = (lc == LC_TEST) ||
                       ((lc != LC_EOL) && lc_authentication_valid &&
                        (lc_authentication_id == auth_id_of(lc)));
    assign trans_hit = lc_transition_request_in && (lc != LC_EOL) &&
                       (lc_transition_id == trans_id_of(lc));
    assign commit    = (state == ST_IDLE) && trans_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            lc       <= LC_TEST;
            rst_req  <= 1'b0;
            bus_wake <= 1'b0;
            op_rel   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_config_n) begin
                        state   <= ST_RST_REQ;
                        rst_req <= 1'b1;
                    end
                end
                ST_RST_REQ: begin
                    if (gpio_in[1]) begin
                        state   <= ST_RST_WAIT;
                        rst_req <= 1'b0;
                    end
                end
                ST_RST_WAIT: begin
                    if (!gpio_in[1]) begin
                        state <= ST_AUTH_CHK;
                    end
                end
                ST_AUTH_CHK: begin
                    if (auth_ok) begin
                        state    <= ST_BUS_WAKE;
                        bus_wake <= 1'b1;
                    end else begin
                        state   <= ST_RST_REQ;
                        rst_req <= 1'b1;
                    end
                end
                ST_BUS_WAKE: begin
                    if (gpio_in[7]) begin
                        bus_wake <= 1'b0;
                        if (lc == LC_TEST) begin
                            state <= ST_IDLE;
                        end else begin
                            state  <= ST_OP_REL;
                            op_rel <= 1'b1;
                        end
                    end
                end
                ST_OP_REL: begin
                    if (gpio_in[5]) begin
                        state  <= ST_IDLE;
                        op_rel <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (trans_hit) begin
                        lc      <= lc_t'(lc + 3'd1);
                        state   <= ST_RST_REQ;
                        rst_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_INIT;
                    rst_req  <= 1'b0;
                    bus_wake <= 1'b0;
                    op_rel   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        gpio_out       = '0;
        gpio_out[0]    = rst_req;
        gpio_out[4]    = op_rel;
        gpio_out[6]    = bus_wake;
        gpio_out[10:8] = lc;
    end

    // The index parks at KEY_DONE; a lifecycle commit re-arms the challenge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_idx     <= '0;
            scan_unlock <= 1'b0;
        end else if (commit) begin
            key_idx     <= '0;
            scan_unlock <= 1'b0;
        end else begin
            if (key_idx != KEY_DONE) begin
                if (scan_key == challenge_word(key_idx[3:0])) begin
                    key_idx <= key_idx + 5'd1;
                end else if (scan_key == challenge_word(4'd0)) begin
                    key_idx <= 5'd1;
                end else begin
                    key_idx <= 5'd0;
                end
            end
            if ((key_idx == KEY_DONE) && (lc != LC_EOL)) begin
                scan_unlock <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            scan_out <= 1'b0;
        end else begin
            scan_out <= shreg[0] & scan_enable & scan_unlock;
            if (!scan_enable) begin
                shreg <= {24'h0, state, 1'b0, lc};
            end else if (scan_unlock) begin
                shreg <= {1'b0, shreg[31:1]};
            end
        end
    end

    assign O_htrans    = 2'b00;
    assign O_haddr     = 32'h0;
    assign O_hwdata    = 32'h0;
    assign O_hwrite    = 1'b0;
    assign O_hburst    = 3'b011;
    assign O_hsize     = 3'b010;
    assign O_hprot     = 4'b0011;
    assign O_hmastlock = 1'b0;
    assign O_hnonsec   = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{I_hrdata, I_hready, I_hresp, I_hreadyout,
                             gpio_in[gpio_N-1:8], gpio_in[6], gpio_in[4:2], gpio_in[0],
                             gpio_AW[0], gpio_PW[0]};

endmodule

// File: tb/tb_mcse_security_top.sv
// Randomized bench for mcse_security_top against a lifecycle/handshake/challenge reference model.
module tb_mcse_security_top;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         init_config_n;
    logic [31:0]  gpio_in;
    logic [31:0]  gpio_out;
    logic         lc_transition_request_in;
    logic [511:0] lc_transition_id;
    logic         lc_authentication_valid;
    logic [511:0] lc_authentication_id;
    logic [31:0]  scan_key;
    logic         scan_enable;
    logic         scan_unlock;
    logic         scan_out;
    logic [31:0]  O_haddr;
    logic [2:0]   O_hburst;
    logic         O_hmastlock;
    logic [3:0]   O_hprot;
    logic         O_hnonsec;
    logic [2:0]   O_hsize;
    logic [1:0]   O_htrans;
    logic [31:0]  O_hwdata;
    logic         O_hwrite;

    int errors = 0;
    int checks = 0;
    int m_lc   = 0;
    int m_idx  = 0;
    bit m_unlock = 1'b0;

    localparam logic [31:0] FILLER = 32'h5A5A_5A5A;
    logic [31:0] words [16] = '{32'hEF012345, 32'h6789ABCD, 32'hEF012345, 32'h7891ABCD,
                                32'h3D4E5F60, 32'hFF8A0B2C, 32'hFA1BC49D, 32'h87A5E932,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    mcse_security_top dut (
        .clk(clk), .rst_n(rst_n), .init_config_n(init_config_n),
        .gpio_in(gpio_in), .gpio_out(gpio_out),
        .lc_transition_request_in(lc_transition_request_in), .lc_transition_id(lc_transition_id),
        .lc_authentication_valid(lc_authentication_valid), .lc_authentication_id(lc_authentication_id),
        .scan_key(scan_key), .scan_enable(scan_enable), .scan_unlock(scan_unlock), .scan_out(scan_out),
        .O_haddr(O_haddr), .O_hburst(O_hburst), .O_hmastlock(O_hmastlock), .O_hprot(O_hprot),
        .O_hnonsec(O_hnonsec), .O_hsize(O_hsize), .O_htrans(O_htrans), .O_hwdata(O_hwdata),
        .O_hwrite(O_hwrite),
        .I_hrdata(32'h0), .I_hready(1'b1), .I_hresp(2'b00), .I_hreadyout(1'b1)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] trans_id(input int from_lc);
        case (from_lc)
            0: return {2{256'h33a344a35afd82155e5a6ef2d092085d704dc70561dde45d27962d79ea56a24a}};
            1: return {2{256'h988b6a57b75f5696f01b8207b1c99bc888b4a2421a0ab4b29bd302f5b8a93348}};
            2: return {2{256'h4893565d146d9fa19dc850e0c409b2a62ec5cb53eea4d4719c93a882f988284e}};
            3: return {2{256'hcabc36e4f52fcd1a8b62d82d975e4c8595da7f6df52e2143174c3dc8b3870e03}};
            default: return '0;
        endcase
    endfunction

    function automatic logic [511:0] auth_id(input int lc);
        case (lc)
            1: return {2{256'h431909d9da263164ab4d39614e0c50a32774a49b3390a53ffa63e8d74b8e7c0b}};
            2: return {2{256'h8e30701845bea3e44d0aed1ba6d4893a0de91fea6f42571d3714a3c6daa39978}};
            3: return {2{256'hd995f5ddfb1625e3a33b0ee123b6672f35df88d6652eaec51d26f3a50b030ad8}};
            4: return {2{256'hdf0f326b1bf6611d944491d7a0618af56ac57e391ba38425f9f33cafdd7439a9}};
            default: return '0;
        endcase
    endfunction

    // Challenge progress rule: advance on the expected word, fall back to 1 on word 0, else 0.
    function automatic int next_idx(input int idx, input logic [31:0] k);
        if (idx >= 16) return idx;
        if (k == words[idx]) return idx + 1;
        return (k == words[0]) ? 1 : 0;
    endfunction

    task automatic wait_bit(input int b, input logic v, input string tag);
        int n = 0;
        while (gpio_out[b] !== v && n < 20) begin
            step();
            n++;
        end
        chk(tag, gpio_out[b], v);
    endtask

    task automatic boot(input logic vld, input logic [511:0] id, input bit fresh, input bit stop_at_wake);
        bit           ok;
        bit           early;
        logic         s_vld;
        logic [511:0] s_id;
        wait_bit(0, 1'b1, "rst_req");
        chk("rst_req_lc", gpio_out[10:8], m_lc);
        chk("rst_req_wake_off", gpio_out[6], 0);
        repeat ($urandom_range(0, 3)) begin
            step();
            chk("rst_req_hold", gpio_out[0], 1);
        end
        gpio_in[1] = 1'b1;
        step();
        chk("rst_req_drop", gpio_out[0], 0);
        repeat ($urandom_range(0, 2)) step();
        gpio_in[1] = 1'b0;
        lc_authentication_valid = vld;
        lc_authentication_id    = id;
        step();
        if (!fresh) lc_authentication_id = rand512();
        s_vld = lc_authentication_valid;
        s_id  = lc_authentication_id;
        step();
        lc_authentication_valid = 1'b0;
        ok = (m_lc == 0) || (m_lc != 4 && s_vld && s_id == auth_id(m_lc));
        if (!ok) begin
            chk("auth_reject_req", gpio_out[0], 1);
            chk("auth_reject_wake", gpio_out[6], 0);
            return;
        end
        chk("bus_wake", gpio_out[6], 1);
        chk("bus_wake_req_off", gpio_out[0], 0);
        if (stop_at_wake) return;
        repeat ($urandom_range(0, 3)) begin
            step();
            chk("bus_wake_hold", gpio_out[6], 1);
        end
        early = 1'($urandom_range(0, 1));
        gpio_in[7] = 1'b1;
        gpio_in[5] = early;
        step();
        gpio_in[7] = 1'b0;
        chk("bus_wake_drop", gpio_out[6], 0);
        if (m_lc == 0) begin
            gpio_in[5] = 1'b0;
            chk("test_skip_op_rel", gpio_out[4], 0);
        end else begin
            chk("op_rel", gpio_out[4], 1);
            if (!early) begin
                repeat ($urandom_range(0, 3)) begin
                    step();
                    chk("op_rel_hold", gpio_out[4], 1);
                end
                gpio_in[5] = 1'b1;
            end
            step();
            gpio_in[5] = 1'b0;
            chk("op_rel_drop", gpio_out[4], 0);
        end
        chk("idle_gpio", gpio_out, 64'(m_lc) << 8);
    endtask

    task automatic transition(input bit good);
        logic [511:0] id;
        if (good) id = trans_id(m_lc);
        else if ($urandom_range(0, 1) != 0) id = rand512();
        else id = trans_id((m_lc + 1) % 4);
        lc_transition_id = id;
        lc_transition_request_in = 1'b0;
        step();
        chk("idle_no_req", gpio_out[0], 0);
        lc_transition_request_in = 1'b1;
        step();
        lc_transition_request_in = 1'b0;
        lc_transition_id = rand512();
        if (good) begin
            m_lc++;
            m_unlock = 1'b0;
            m_idx = 0;
        end
        chk("trans_req", gpio_out[0], good);
        chk("trans_lc", gpio_out[10:8], m_lc);
        chk("trans_unlock", scan_unlock, m_unlock);
        if (!good) begin
            repeat (2) step();
            chk("trans_ignored", gpio_out, 64'(m_lc) << 8);
        end
    endtask

    task automatic challenge(input int bad_pos);
        logic [31:0] w;
        bit reached;
        for (int i = 0; i < 16; i++) begin
            w = words[i];
            if (i == bad_pos) w = w ^ (32'h1 << $urandom_range(0, 31));
            scan_key = w;
            m_idx = next_idx(m_idx, w);
            step();
        end
        chk("unlock_not_early", scan_unlock, m_unlock);
        scan_key = FILLER;
        reached = (m_idx == 16);
        m_idx = next_idx(m_idx, FILLER);
        step();
        if (reached && m_lc != 4) m_unlock = 1'b1;
        chk("unlock", scan_unlock, m_unlock);
    endtask

    task automatic scan_check();
        logic [2:0] lcb;
        lcb = 3'(m_lc);
        scan_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("scan_bit", scan_out, m_unlock ? lcb[k] : 1'b0);
        end
        scan_enable = 1'b0;
        step();
        chk("scan_off", scan_out, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        init_config_n = 1'b0;
        gpio_in = '0;
        lc_transition_request_in = 1'b0;
        lc_transition_id = '0;
        lc_authentication_valid = 1'b0;
        lc_authentication_id = '0;
        scan_key = FILLER;
        scan_enable = 1'b0;
        #12;
        chk("rst_gpio", gpio_out, 0);
        chk("rst_unlock", scan_unlock, 0);
        chk("rst_scan_out", scan_out, 0);
        chk("ahb_ctl", {O_htrans, O_hburst, O_hsize, O_hprot, O_hwrite, O_hmastlock, O_hnonsec},
            {2'b00, 3'b011, 3'b010, 4'b0011, 3'b000});
        chk("ahb_data", {O_haddr, O_hwdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        chk("init_hold", gpio_out, 0);
        init_config_n = 1'b1;

        boot(1'($urandom_range(0, 1)), rand512(), 1'b1, 1'b0);
        challenge(-1);
        scan_check();
        transition(1'b0);
        transition(1'b1);

        boot(1'b0, auth_id(1), 1'b1, 1'b0);
        boot(1'b1, rand512(), 1'b1, 1'b0);
        boot(1'b1, auth_id(1), 1'b0, 1'b0);
        boot(1'b1, auth_id(2), 1'b1, 1'b0);
        boot(1'b1, auth_id(1), 1'b1, 1'b0);
        scan_check();
        challenge($urandom_range(1, 14));
        scan_check();
        challenge(-1);
        scan_check();
        transition(1'b0);
        transition(1'b1);

        boot(1'b1, auth_id(2), 1'b1, 1'b0);
        challenge(-1);
        scan_check();
        transition(1'b1);
        boot(1'b1, auth_id(3), 1'b1, 1'b0);
        transition(1'b0);
        transition(1'b1);

        repeat (3) boot(1'b1, auth_id(4), 1'b1, 1'b0);
        challenge(-1);

        rst_n = 1'b0;
        #2;
        chk("eol_rst_gpio", gpio_out, 0);
        m_lc = 0; m_idx = 0; m_unlock = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        boot(1'b0, '0, 1'b1, 1'b0);
        transition(1'b1);
        challenge(-1);
        boot(1'b1, auth_id(1), 1'b1, 1'b1);

        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_gpio", gpio_out, 0);
        chk("midrst_unlock", scan_unlock, 0);
        chk("midrst_scan_out", scan_out, 0);
        m_lc = 0; m_idx = 0; m_unlock = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        boot(1'b0, '0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
